// File: rtl/change_pkg.sv
// Shared types and encodings for the change dispenser: coin codes,
// controller states and the inventory load-select mapping.
package change_pkg;

  typedef enum logic [1:0] {
    C50  = 2'd0,
    C100 = 2'd1,
    C200 = 2'd2
  } coin_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EJECT = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam int NCOIN = 3;

  localparam logic [1:0] LSEL_50   = 2'b00;
  localparam logic [1:0] LSEL_100  = 2'b01;
  localparam logic [1:0] LSEL_200  = 2'b10;
  localparam logic [1:0] LSEL_NONE = 2'b11;

  // Solenoid vector bit for a coin: bit0 = 0,50, bit1 = 1,00, bit2 = 2,00.
  function automatic logic [2:0] coin_onehot(input coin_t c);
    logic [2:0] v;
    case (c)
      C50:     v = 3'b001;
      C100:    v = 3'b010;
      C200:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] coin_lsel(input coin_t c);
    logic [1:0] s;
    case (c)
      C50:     s = LSEL_50;
      C100:    s = LSEL_100;
      C200:    s = LSEL_200;
      default: s = LSEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small request queue for coin codes; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module coin_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A push into a full queue is still accepted when the head leaves this cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign wr_d = wr_en ? wr_q + (AW+1)'(1) : wr_q;
  assign rd_d = rd_en ? rd_q + (AW+1)'(1) : rd_q;

  assign dout = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Coin hopper controller: queues one-coin change requests, pulses one eject
// solenoid at a time, confirms each drop via the exit sensor and keeps stock.
module change_dispenser
  import change_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INV_W   = 8,
  parameter int PULSE_W = 4,
  parameter int TIMEOUT = 16,
  parameter int GAP_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t50,
  input  logic             t100,
  input  logic             t200,
  input  logic             coin_seen,
  input  logic             load,
  input  logic [1:0]       load_sel,
  input  logic [INV_W-1:0] load_val,
  input  logic             clr_fault,
  output logic             eject50,
  output logic             eject100,
  output logic             eject200,
  output logic             busy,
  output logic             fault,
  output logic             short,
  output logic             overflow,
  output logic [INV_W-1:0] inv50,
  output logic [INV_W-1:0] inv100,
  output logic [INV_W-1:0] inv200
);

  // One counter serves the pulse length, the drop timeout and the gap (GAP_W >= 1).
  localparam int CNT_MAX = (TIMEOUT > PULSE_W) ? ((TIMEOUT > GAP_W) ? TIMEOUT : GAP_W)
                                               : ((PULSE_W > GAP_W) ? PULSE_W : GAP_W);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

  state_t           state_q, state_d;
  coin_t            coin_q, coin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       eject_q, eject_d;
  logic             short_q, short_d;
  logic             ovf_q, ovf_d;
  logic [INV_W-1:0] inv_q [NCOIN];
  logic [INV_W-1:0] inv_d [NCOIN];

  logic [2:0]       req;
  logic             req_one;
  logic             req_multi;
  coin_t            req_code;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       head_raw;
  coin_t            head;
  logic [INV_W-1:0] head_inv;
  logic             dec;

  assign req       = {t200, t100, t50};
  assign req_one   = $onehot(req);
  assign req_multi = (req != 3'b000) && !req_one;
  assign req_code  = t200 ? C200 : (t100 ? C100 : C50);

  coin_fifo #(
    .DEPTH (DEPTH),
    .W     (2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_one),
    .pop   (fifo_pop),
    .din   (req_code),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = coin_t'(head_raw);

  always_comb begin
    case (head)
      C100:    head_inv = inv_q[1];
      C200:    head_inv = inv_q[2];
      default: head_inv = inv_q[0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    coin_d   = coin_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    short_d  = 1'b0;
    dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_inv != '0) begin
            state_d = EJECT;
            coin_d  = head;
            cnt_d   = '0;
          end else begin
            short_d = 1'b1;
          end
        end
      end
      EJECT, WAIT: begin
        // A drop seen on the last allowed cycle still counts as a success.
        if (coin_seen) begin
          dec     = 1'b1;
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == EJECT && cnt_q == PULSE_LAST) begin
            state_d = WAIT;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FAULT: begin
        if (clr_fault) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Solenoids follow the next state so the line drops on the edge that sees the coin.
  assign eject_d = (state_d == EJECT) ? coin_onehot(coin_d) : 3'b000;

  assign ovf_d = ovf_q || req_multi || (req_one && fifo_full && !fifo_pop);

  for (genvar gi = 0; gi < NCOIN; gi++) begin : g_inv
    logic sel_hit;
    logic dec_hit;
    assign sel_hit = load && (load_sel == coin_lsel(coin_t'(gi)));
    assign dec_hit = dec && (coin_q == coin_t'(gi)) && (inv_q[gi] != '0);
    assign inv_d[gi] = sel_hit ? load_val
                     : dec_hit ? inv_q[gi] - INV_W'(1)
                     : inv_q[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      coin_q  <= C50;
      cnt_q   <= '0;
      eject_q <= 3'b000;
      short_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NCOIN; i++) begin
        inv_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      cnt_q   <= cnt_d;
      eject_q <= eject_d;
      short_q <= short_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NCOIN; i++) begin
        inv_q[i] <= inv_d[i];
      end
    end
  end

  assign eject50  = eject_q[0];
  assign eject100 = eject_q[1];
  assign eject200 = eject_q[2];
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign fault    = (state_q == FAULT);
  assign short    = short_q;
  assign overflow = ovf_q;
  assign inv50    = inv_q[0];
  assign inv100   = inv_q[1];
  assign inv200   = inv_q[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected events from a
// request-level model, a monitor pops them as ejects, shorts and faults appear.
module tb_change_dispenser;

  localparam int DEPTH   = 4;
  localparam int INV_W   = 8;
  localparam int PULSE_W = 4;
  localparam int TIMEOUT = 16;
  localparam int GAP_W   = 2;

  localparam int EV_EJECT = 0;
  localparam int EV_SHORT = 1;
  localparam int EV_FAULT = 2;

  typedef struct {
    int kind;
    int coin;
    int len;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             t50 = 1'b0;
  logic             t100 = 1'b0;
  logic             t200 = 1'b0;
  logic             coin_seen;
  logic             load = 1'b0;
  logic [1:0]       load_sel = 2'b00;
  logic [INV_W-1:0] load_val = '0;
  logic             clr_fault;
  logic             eject50, eject100, eject200;
  logic             busy, fault, short, overflow;
  logic [INV_W-1:0] inv50, inv100, inv200;

  ev_t  exp_q[$];
  int   plan_q[$];
  int   inv_m[3];
  int   issued = 0;
  int   started = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   cyc = 0;
  logic [2:0] ej_prev_r = 3'b000;

  change_dispenser #(
    .DEPTH   (DEPTH),
    .INV_W   (INV_W),
    .PULSE_W (PULSE_W),
    .TIMEOUT (TIMEOUT),
    .GAP_W   (GAP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .t50       (t50),
    .t100      (t100),
    .t200      (t200),
    .coin_seen (coin_seen),
    .load      (load),
    .load_sel  (load_sel),
    .load_val  (load_val),
    .clr_fault (clr_fault),
    .eject50   (eject50),
    .eject100  (eject100),
    .eject200  (eject200),
    .busy      (busy),
    .fault     (fault),
    .short     (short),
    .overflow  (overflow),
    .inv50     (inv50),
    .inv100    (inv100),
    .inv200    (inv200)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    ej_prev_r <= {eject200, eject100, eject50};
  end

  task automatic check(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input int kind, output ev_t e, output bit ok);
    e = '{kind: -1, coin: -1, len: 0};
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      ok = 1'b0;
      $display("FAIL unexpected_event: got kind %0d, expected no event (cycle %0d)", kind, cyc);
    end else begin
      e  = exp_q.pop_front();
      ok = (e.kind == kind);
      check("event_kind", kind, e.kind);
    end
  endtask

  // Request-level model: the outcome follows from stock on hand and the hopper plan.
  task automatic model_req(input int c, input int d);
    ev_t e;
    e.coin = c;
    e.len  = 0;
    if (inv_m[c] == 0) begin
      e.kind = EV_SHORT;
      exp_q.push_back(e);
    end else begin
      e.kind = EV_EJECT;
      e.len  = (d == 0 || d > PULSE_W) ? PULSE_W : d;
      exp_q.push_back(e);
      plan_q.push_back(d);
      if (d == 0) begin
        e.kind = EV_FAULT;
        exp_q.push_back(e);
      end else begin
        inv_m[c]--;
      end
    end
    issued++;
  endtask

  task automatic pulse_req(input logic [2:0] v);
    {t200, t100, t50} = v;
    @(negedge clk);
    {t200, t100, t50} = 3'b000;
  endtask

  task automatic send(input int c, input int d);
    int w;
    logic [2:0] v;
    w = 0;
    while ((issued - started) >= DEPTH && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("queue_room", int'((issued - started) < DEPTH), 1);
    v = 3'(1 << c);
    model_req(c, d);
    pulse_req(v);
  endtask

  task automatic load_inv(input int sel, input int val);
    load     = 1'b1;
    load_sel = 2'(sel);
    load_val = INV_W'(val);
    @(negedge clk);
    load = 1'b0;
    if (sel < 3) inv_m[sel] = val;
  endtask

  task automatic check_inv();
    check("inv50", int'(inv50), inv_m[0]);
    check("inv100", int'(inv100), inv_m[1]);
    check("inv200", int'(inv200), inv_m[2]);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy || fault) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("idle_reached", int'(!busy && !fault), 1);
    repeat (2) @(negedge clk);
    check("events_drained", exp_q.size(), 0);
  endtask

  task automatic wait_started(input int s0);
    int w;
    w = 0;
    while (started == s0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("eject_started", int'(started != s0), 1);
  endtask

  // Monitor: every eject rise, short cycle and fault rise consumes one expected event.
  logic [2:0] mon_ej;
  ev_t        mon_e;
  bit         mon_ok;
  bit         run_on = 1'b0;
  bit         have_fall = 1'b0;
  logic       fault_prev = 1'b0;
  int         run_len = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;

  always @(negedge clk) begin
    mon_ej = {eject200, eject100, eject50};
    if (rst) begin
      run_on     = 1'b0;
      have_fall  = 1'b0;
      fault_prev = 1'b0;
    end else begin
      if (mon_ej != 3'b000 && ej_prev_r == 3'b000) begin
        started++;
        check("eject_onehot", $countones(mon_ej), 1);
        if (have_fall) check("eject_gap", int'((cyc - fall_cyc) >= GAP_W), 1);
        rise_cyc = cyc;
        expect_event(EV_EJECT, mon_e, mon_ok);
        run_on = mon_ok;
        if (mon_ok) begin
          check("eject_coin", int'(mon_ej), 1 << mon_e.coin);
          run_len = mon_e.len;
        end
        $display("[%0d] eject start lines=%b", cyc, mon_ej);
      end
      if (mon_ej == 3'b000 && ej_prev_r != 3'b000 && run_on) begin
        check("eject_len", cyc - rise_cyc, run_len);
        $display("[%0d] eject end after %0d cycles", cyc, cyc - rise_cyc);
        run_on    = 1'b0;
        have_fall = 1'b1;
        fall_cyc  = cyc;
      end
      if (short) begin
        started++;
        expect_event(EV_SHORT, mon_e, mon_ok);
        $display("[%0d] short pulse", cyc);
      end
      if (fault && !fault_prev) begin
        expect_event(EV_FAULT, mon_e, mon_ok);
        check("fault_delay", cyc - rise_cyc, TIMEOUT);
        $display("[%0d] fault raised", cyc);
      end
      fault_prev = fault;
    end
  end

  // Hopper: answers each eject with the planned sensor delay (0 = coin never drops).
  initial begin : hopper
    int d;
    coin_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && {eject200, eject100, eject50} != 3'b000 && ej_prev_r == 3'b000) begin
        d = (plan_q.size() > 0) ? plan_q.pop_front() : 0;
        if (d > 0) begin
          repeat (d - 1) @(negedge clk);
          if (!rst) coin_seen = 1'b1;
          @(negedge clk);
          coin_seen = 1'b0;
        end
      end
    end
  end

  initial begin : fault_clear
    clr_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && fault) begin
        repeat (2) @(negedge clk);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s0;
    int c;
    int d;
    for (int i = 0; i < 3; i++) inv_m[i] = 0;

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_ejects", int'({eject200, eject100, eject50}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_short", int'(short), 0);
    check("rst_overflow", int'(overflow), 0);
    check_inv();

    // Single t100 with the coin sensed 3 cycles after the eject rises.
    load_inv(0, 3);
    load_inv(1, 3);
    load_inv(2, 3);
    check_inv();
    model_req(1, 3);
    t100 = 1'b1;
    @(negedge clk);
    t100 = 1'b0;
    @(negedge clk);
    check("latency_eject100", int'(eject100), 1);
    wait_idle();
    check_inv();

    // Back-to-back requests of every denomination.
    send(0, 2);
    send(1, 2);
    send(2, 2);
    wait_idle();
    check_inv();

    // Empty 2,00 stock: short pulse, then the queued 0,50 proceeds.
    load_inv(2, 0);
    send(2, 2);
    send(0, 2);
    wait_idle();
    check_inv();

    // Coin never drops: fault after TIMEOUT, cleared, next request served.
    send(1, 0);
    send(0, 2);
    wait_idle();
    check_inv();

    // Flood the queue while the first coin is pending in WAIT.
    load_inv(0, 9);
    load_inv(1, 9);
    load_inv(2, 9);
    check("overflow_before", int'(overflow), 0);
    s0 = started;
    send(0, 10);
    wait_started(s0);
    for (int i = 0; i < 6; i++) begin
      if (i < DEPTH) model_req(1, 2);
      pulse_req(3'b010);
    end
    pulse_req(3'b011);
    check("overflow_set", int'(overflow), 1);
    wait_idle();
    check("overflow_sticky", int'(overflow), 1);
    check_inv();

    // Randomized requests, hopper delays and inventory reloads.
    load_inv(0, 4);
    load_inv(1, 4);
    load_inv(2, 4);
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        load_inv(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        check_inv();
      end else begin
        c = int'($urandom_range(0, 2));
        d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
        send(c, d);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle();
    check_inv();

    // Asynchronous reset in the middle of an eject with a request still queued.
    load_inv(2, 5);
    load_inv(0, 5);
    s0 = started;
    send(2, 0);
    send(0, 2);
    wait_started(s0);
    #2 rst = 1'b1;
    #1;
    check("arst_ejects", int'({eject200, eject100, eject50}), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_inv50", int'(inv50), 0);
    check("arst_inv200", int'(inv200), 0);
    exp_q.delete();
    plan_q.delete();
    for (int i = 0; i < 3; i++) inv_m[i] = 0;
    issued = started;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_overflow", int'(overflow), 0);
    check_inv();
    check("post_rst_events", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
